// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared state encoding and counter-width helpers for the
//            fully-connected systolic array sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fc_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } fc_state_e;

  // Ceiling log2, never below one bit so counters stay legal vectors
  function automatic int fc_clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  // Beat counter must reach K = 2^NUM
  function automatic int fc_beat_w(input int num);
    return num + 1;
  endfunction

  // Flush counter spans up to ROWS+COLS-2 cycles
  function automatic int fc_flush_w(input int rows, input int cols);
    return fc_clog2_min1(rows + cols);
  endfunction

  // Timeout counter spans up to TIMEOUT cycles
  function automatic int fc_to_w(input int timeout);
    return fc_clog2_min1(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_skew_line.sv
`default_nettype none
// ============================================================================
// Module   : fc_skew_line
// Purpose  : Enable-gated shift register feeding one edge lane of the grid.
//            DEPTH extra stages follow the always-present input register, so
//            DEPTH=0 is a single registered stage.
// Revision : 1.0 - initial release
// ============================================================================
module fc_skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [0:DEPTH];
  logic [W-1:0] stage_d [0:DEPTH];

  // Shift one position on enable; clear wipes the whole line
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = d;
      for (int i = 1; i <= DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
    if (clr) begin
      for (int i = 0; i <= DEPTH; i++) begin
        stage_d[i] = '0;
      end
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH];

endmodule
`default_nettype wire

// File: rtl/fc_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fc_array_ctrl
// Purpose  : Job sequencer for a ROWS x COLS fully-connected systolic grid.
//            Pulls K operand beats, skews them onto the grid edges, flushes
//            with zeros, then waits for the grid's final valid.
// Revision : 1.0 - initial release
// ============================================================================
module fc_array_ctrl
  import fc_pkg::*;
#(
  parameter int ROWS    = 2,
  parameter int COLS    = 2,
  parameter int NUM     = 3,
  parameter int INL     = 8,
  parameter int INT     = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [NUM:0]        cmd_k,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [ROWS*INL-1:0] vec_a,
  input  logic [COLS*INT-1:0] vec_b,
  output logic                pe_start,
  output logic [ROWS*INL-1:0] left_data,
  output logic [COLS*INT-1:0] top_data,
  input  logic                arr_valid,
  output logic                done,
  output logic                err,
  output logic                busy
);

  localparam int BEAT_W    = fc_beat_w(NUM);
  localparam int FLUSH_W   = fc_flush_w(ROWS, COLS);
  localparam int TO_W      = fc_to_w(TIMEOUT);
  localparam int FLUSH_LEN = ROWS + COLS - 2;

  localparam logic [FLUSH_W-1:0] FLUSH_LAST =
    FLUSH_W'((FLUSH_LEN == 0) ? 0 : FLUSH_LEN - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  fc_state_e           state_q, state_d;
  logic [BEAT_W-1:0]   k_q, k_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   beat_inc;
  logic [FLUSH_W-1:0]  flush_q, flush_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                pe_start_q, pe_start_d;
  logic                err_q, err_d;

  logic                adv;
  logic                zero_fill;
  logic                skew_clr;
  logic [ROWS*INL-1:0] row_in;
  logic [COLS*INT-1:0] col_in;

  assign beat_inc = beat_q + BEAT_W'(1);

  // Next-state, counter and advance decode
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    beat_d     = beat_q;
    flush_d    = flush_q;
    to_d       = to_q;
    err_d      = 1'b0;
    adv        = 1'b0;
    zero_fill  = 1'b0;
    skew_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          k_d      = cmd_k;
          beat_d   = '0;
          flush_d  = '0;
          to_d     = '0;
          skew_clr = 1'b1;
          state_d  = (cmd_k == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (vec_valid) begin
          adv    = 1'b1;
          beat_d = beat_inc;
          if (beat_inc == k_q) begin
            state_d = (FLUSH_LEN == 0) ? WAIT : FLUSH;
          end
        end
      end
      FLUSH: begin
        adv       = 1'b1;
        zero_fill = 1'b1;
        flush_d   = flush_q + FLUSH_W'(1);
        if (flush_q == FLUSH_LAST) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (arr_valid) begin
          state_d = DONE;
        end else if (to_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pe_start_d = adv;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      beat_q     <= '0;
      flush_q    <= '0;
      to_q       <= '0;
      pe_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      beat_q     <= beat_d;
      flush_q    <= flush_d;
      to_q       <= to_d;
      pe_start_q <= pe_start_d;
      err_q      <= err_d;
    end
  end

  assign row_in = zero_fill ? '0 : vec_a;
  assign col_in = zero_fill ? '0 : vec_b;

  // Row r is delayed by r advances so the wavefront enters diagonally
  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
      fc_skew_line #(
        .DEPTH (r),
        .W     (INL)
      ) u_row_skew (
        .clk   (clk),
        .reset (reset),
        .clr   (skew_clr),
        .en    (adv),
        .d     (row_in[r*INL +: INL]),
        .q     (left_data[r*INL +: INL])
      );
    end
  endgenerate

  // Column c is delayed by c advances
  generate
    for (genvar c = 0; c < COLS; c++) begin : g_col_skew
      fc_skew_line #(
        .DEPTH (c),
        .W     (INT)
      ) u_col_skew (
        .clk   (clk),
        .reset (reset),
        .clr   (skew_clr),
        .en    (adv),
        .d     (col_in[c*INT +: INT]),
        .q     (top_data[c*INT +: INT])
      );
    end
  endgenerate

  assign pe_start  = pe_start_q;
  assign err       = err_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign cmd_ready = (state_q == IDLE);
  assign vec_ready = (state_q == LOAD);

endmodule
`default_nettype wire
